// File: rtl/round_pkg.sv
// Shared widths, modulus and subblock type for the round datapath.
package round_pkg;
  localparam int SUB_W = 16;
  localparam int BLK_W = 64;
  localparam int KEY_W = 96;
  localparam int unsigned MUL_MOD = 65537;

  typedef logic [SUB_W-1:0] sub_t;
endpackage

// File: rtl/idea_mul16.sv
// Multiplication mod 65537 with 0 standing for 65536; purely combinational.
// No state and no handshake; the result settles in the same cycle.
module idea_mul16
  import round_pkg::*;
(
  input  sub_t a,
  input  sub_t b,
  output sub_t y
);

  localparam logic [19:0] MOD20 = 20'(MUL_MOD);

  logic [16:0] a17;
  logic [16:0] b17;
  logic [33:0] prod;
  logic [19:0] diff;

  // 2^16 == -1 (mod 65537), so hi*2^16 + lo reduces to lo - hi, lifted by one modulus to stay positive.
  always_comb begin
    a17  = (a == '0) ? 17'h10000 : {1'b0, a};
    b17  = (b == '0) ? 17'h10000 : {1'b0, b};
    prod = {17'b0, a17} * {17'b0, b17};
    diff = {4'b0, prod[15:0]} + MOD20 - {2'b0, prod[33:16]};
    y    = sub_t'((diff >= MOD20) ? (diff - MOD20) : diff);
  end

endmodule

// File: rtl/round.sv
// One full round with output transform; one-cycle latency, one block per cycle, no backpressure.
// ROUND_STEP_DEBUG_EN registers step1..step10 for debug; otherwise those ports are tied to 0.
module round
  import round_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [BLK_W-1:0] in,
  input  logic [KEY_W-1:0] key,
  output logic             out_valid,
  output logic [BLK_W-1:0] out,
  output logic [SUB_W-1:0] step1,
  output logic [SUB_W-1:0] step2,
  output logic [SUB_W-1:0] step3,
  output logic [SUB_W-1:0] step4,
  output logic [SUB_W-1:0] step5,
  output logic [SUB_W-1:0] step6,
  output logic [SUB_W-1:0] step7,
  output logic [SUB_W-1:0] step8,
  output logic [SUB_W-1:0] step9,
  output logic [SUB_W-1:0] step10
);

  sub_t x1, x2, x3, x4;
  sub_t k1, k2, k3, k4, k5, k6;
  sub_t s1, s2, s3, s4, s5, s6, s7, s8, s9, s10;
  sub_t y1, y2, y3, y4;

  assign {x1, x2, x3, x4}         = in;
  assign {k1, k2, k3, k4, k5, k6} = key;

  idea_mul16 u_mul1 (.a(x1), .b(k1), .y(s1));
  idea_mul16 u_mul4 (.a(x4), .b(k4), .y(s4));
  idea_mul16 u_mul7 (.a(s5), .b(k5), .y(s7));
  idea_mul16 u_mul9 (.a(s8), .b(k6), .y(s9));

  assign s2  = x2 + k2;
  assign s3  = x3 + k3;
  assign s5  = s1 ^ s3;
  assign s6  = s2 ^ s4;
  assign s8  = s6 + s7;
  assign s10 = s7 + s9;

  // Middle words swap on the way out.
  assign y1 = s1 ^ s9;
  assign y2 = s3 ^ s9;
  assign y3 = s2 ^ s10;
  assign y4 = s4 ^ s10;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out       <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        out <= {y1, y2, y3, y4};
      end
    end
  end

`ifdef ROUND_STEP_DEBUG_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step1  <= '0;
      step2  <= '0;
      step3  <= '0;
      step4  <= '0;
      step5  <= '0;
      step6  <= '0;
      step7  <= '0;
      step8  <= '0;
      step9  <= '0;
      step10 <= '0;
    end else if (in_valid) begin
      step1  <= s1;
      step2  <= s2;
      step3  <= s3;
      step4  <= s4;
      step5  <= s5;
      step6  <= s6;
      step7  <= s7;
      step8  <= s8;
      step9  <= s9;
      step10 <= s10;
    end
  end
`else
  assign step1  = '0;
  assign step2  = '0;
  assign step3  = '0;
  assign step4  = '0;
  assign step5  = '0;
  assign step6  = '0;
  assign step7  = '0;
  assign step8  = '0;
  assign step9  = '0;
  assign step10 = '0;
`endif

endmodule

// File: tb/tb_round.sv
// Directed bench for round: hand-computed vectors, reset, mul/add boundaries, valid handshake.
module tb_round;

`ifdef ROUND_STEP_DEBUG_EN
  localparam bit DBG = 1'b1;
`else
  localparam bit DBG = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [63:0] in;
  logic [95:0] key;
  logic        out_valid;
  logic [63:0] out;
  logic [15:0] step1, step2, step3, step4, step5, step6, step7, step8, step9, step10;

  int checks = 0;
  int errors = 0;

  round dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in(in), .key(key),
    .out_valid(out_valid), .out(out),
    .step1(step1), .step2(step2), .step3(step3), .step4(step4), .step5(step5),
    .step6(step6), .step7(step7), .step8(step8), .step9(step9), .step10(step10)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hand-computed vectors: inputs, expected out, expected {step1..step10}.
  localparam logic [63:0]  ZERO_IN   = 64'h0000_0000_0000_0000;
  localparam logic [95:0]  ZERO_KEY  = 96'h0000_0000_0000_0000_0000_0000;
  localparam logic [63:0]  ZERO_OUT  = 64'h0001_0000_0000_0001;
  localparam logic [159:0] ZERO_ST   = 160'h0001_0000_0000_0001_0001_0001_0000_0001_0000_0000;

  localparam logic [63:0]  ONES_IN   = 64'h0001_0001_0001_0001;
  localparam logic [95:0]  ONES_KEY  = 96'h0001_0001_0001_0001_0001_0001;
  localparam logic [63:0]  ONES_OUT  = 64'h0007_0004_000B_0008;
  localparam logic [159:0] ONES_ST   = 160'h0001_0002_0002_0001_0003_0003_0003_0006_0006_0009;

  localparam logic [63:0]  MULA_IN   = 64'h0002_0000_0000_0000;
  localparam logic [95:0]  MULA_KEY  = 96'h8000_0000_0000_0000_0000_0000;
  localparam logic [63:0]  MULA_OUT  = 64'hFFFF_FFFF_0000_0001;
  localparam logic [159:0] MULA_ST   = 160'h0000_0000_0000_0001_0000_0001_0001_0002_FFFF_0000;

  localparam logic [63:0]  MULC_IN   = 64'h0000_0000_0000_0000;
  localparam logic [95:0]  MULC_KEY  = 96'h0002_0000_0000_0000_0000_0000;
  localparam logic [63:0]  MULC_OUT  = 64'h0001_FFFE_0000_0001;
  localparam logic [159:0] MULC_ST   = 160'hFFFF_0000_0000_0001_FFFF_0001_0002_0003_FFFE_0000;

  localparam logic [63:0]  ADDW_IN   = 64'h0000_FFFF_0000_0000;
  localparam logic [95:0]  ADDW_KEY  = 96'h0000_0001_0000_0000_0000_0000;
  localparam logic [63:0]  ADDW_OUT  = 64'h0001_0000_0000_0001;
  localparam logic [159:0] ADDW_ST   = 160'h0001_0000_0000_0001_0001_0001_0000_0001_0000_0000;

  localparam logic [63:0]  MIX_IN    = 64'h0002_0003_0004_0005;
  localparam logic [95:0]  MIX_KEY   = 96'h0001_0002_0003_0004_0005_0006;
  localparam logic [63:0]  MIX_OUT   = 64'h00FE_00FB_0110_0101;
  localparam logic [159:0] MIX_ST    = 160'h0002_0005_0007_0014_0005_0011_0019_002A_00FC_0115;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_steps(input string tag, input logic [159:0] exp);
    logic [159:0] obs;
    obs = {step1, step2, step3, step4, step5, step6, step7, step8, step9, step10};
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("%s.step%0d", tag, i + 1), {48'b0, obs[159 - 16*i -: 16]},
          DBG ? {48'b0, exp[159 - 16*i -: 16]} : 64'h0);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [63:0] d, input logic [95:0] k);
    in_valid = v;
    in       = d;
    key      = k;
  endtask

  task automatic run(input string tag, input logic [63:0] d, input logic [95:0] k,
                     input logic [63:0] exp_out, input logic [159:0] exp_st);
    drive(1'b1, d, k);
    tick();
    chk({tag, ".valid"}, {63'b0, out_valid}, 64'h1);
    chk({tag, ".out"}, out, exp_out);
    chk_steps(tag, exp_st);
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, ZERO_IN, ZERO_KEY);
    repeat (2) tick();
    chk("reset.valid", {63'b0, out_valid}, 64'h0);
    chk("reset.out", out, 64'h0);
    chk_steps("reset", 160'h0);
    rst_n = 1'b1;

    run("zero", ZERO_IN, ZERO_KEY, ZERO_OUT, ZERO_ST);
    run("ones", ONES_IN, ONES_KEY, ONES_OUT, ONES_ST);
    run("mul_2x8000", MULA_IN, MULA_KEY, MULA_OUT, MULA_ST);
    run("mul_0x0", ZERO_IN, ZERO_KEY, ZERO_OUT, ZERO_ST);
    run("mul_0x2", MULC_IN, MULC_KEY, MULC_OUT, MULC_ST);
    run("add_wrap", ADDW_IN, ADDW_KEY, ADDW_OUT, ADDW_ST);
    run("mix", MIX_IN, MIX_KEY, MIX_OUT, MIX_ST);

    // Idle gap, then three back-to-back blocks, then idle with inputs changed.
    drive(1'b0, ONES_IN, ONES_KEY);
    tick();
    chk("gap.valid", {63'b0, out_valid}, 64'h0);
    chk("gap.out_held", out, MIX_OUT);
    run("b2b0", ONES_IN, ONES_KEY, ONES_OUT, ONES_ST);
    run("b2b1", MIX_IN, MIX_KEY, MIX_OUT, MIX_ST);
    run("b2b2", MULC_IN, MULC_KEY, MULC_OUT, MULC_ST);
    drive(1'b0, MIX_IN, MIX_KEY);
    tick();
    chk("idle1.valid", {63'b0, out_valid}, 64'h0);
    chk("idle1.out_held", out, MULC_OUT);
    chk_steps("idle1", MULC_ST);
    tick();
    chk("idle2.valid", {63'b0, out_valid}, 64'h0);
    chk("idle2.out_held", out, MULC_OUT);

    // Reset asserted mid-stream between edges must clear outputs at once.
    run("pre_rst", MIX_IN, MIX_KEY, MIX_OUT, MIX_ST);
    drive(1'b1, ONES_IN, ONES_KEY);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst.valid", {63'b0, out_valid}, 64'h0);
    chk("midrst.out", out, 64'h0);
    chk_steps("midrst", 160'h0);
    tick();
    chk("inrst.valid", {63'b0, out_valid}, 64'h0);
    chk("inrst.out", out, 64'h0);
    rst_n = 1'b1;
    run("post_rst", ONES_IN, ONES_KEY, ONES_OUT, ONES_ST);

    drive(1'b0, ZERO_IN, ZERO_KEY);
    tick();
    chk("end.valid", {63'b0, out_valid}, 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/round.md
ROUND -- requirements
Module: round

Interface
REQ-001 SHALL have no parameters; the subblock width is fixed at 16 bits and the block width at 64 bits.
REQ-002 SHALL have port clk, input, 1 bit: single clock, all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port in_valid, input, 1 bit: qualifies in/key for capture.
REQ-005 SHALL have port in, input, 64 bits: data block X1..X4, with X1=in[63:48] and X4=in[15:0].
REQ-006 SHALL have port key, input, 96 bits: subkeys K1..K6, with K1=key[95:80] and K6=key[15:0].
REQ-007 SHALL have port out_valid, output, 1 bit: out/step outputs hold a new result.
REQ-008 SHALL have port out, output, 64 bits: round result Y1..Y4, with Y1 in the MSBs.
REQ-009 SHALL have ports step1..step10, output, 16 bits each: intermediate round values (debug).

Function
REQ-010 SHALL define mul(a,b) as multiplication mod 65537, where a 16-bit 0 operand means 65536 and a result of 65536 encodes as 0.
REQ-011 SHALL define add(a,b) as (a+b) mod 65536, and SHALL use bitwise XOR for xor.
REQ-012 SHALL compute step1..step4 as: step1=mul(X1,K1); step2=add(X2,K2); step3=add(X3,K3); step4=mul(X4,K4).
REQ-013 SHALL compute step5..step8 as: step5=step1 xor step3; step6=step2 xor step4; step7=mul(step5,K5); step8=add(step6,step7).
REQ-014 SHALL compute step9 and step10 as: step9=mul(step8,K6); step10=add(step7,step9).
REQ-015 SHALL compute the outputs with the middle words swapped: Y1=step1 xor step9; Y2=step3 xor step9; Y3=step2 xor step10; Y4=step4 xor step10.
REQ-016 SHALL compute the datapath combinationally and register out, step1..step10 and out_valid, giving a latency of exactly 1 cycle from in_valid to out_valid.
REQ-017 SHALL capture a new result every cycle in which in_valid=1, with no backpressure and a throughput of 1 block per cycle.
REQ-018 SHALL, when in_valid=0, hold out and step registers at their previous values and drive out_valid=0 on the next edge.
REQ-019 SHALL make all arithmetic widths exact, with no truncation error in mul, which needs a 17x17 product reduced mod 65537.

Reset
REQ-020 SHALL clear out, step1..step10 and out_valid to 0 immediately when rst_n=0, regardless of clk.
REQ-021 SHALL, on reset asserted mid-stream, discard the in-flight result; the first valid result after release comes from the first in_valid sampled with rst_n=1.

Configuration
REQ-022 SHALL, with ROUND_STEP_DEBUG_EN defined, drive step1..step10 from the registered intermediates per REQ-012..REQ-014.
REQ-023 SHALL, without ROUND_STEP_DEBUG_EN, keep ports step1..step10 present but tied to 0 with no step registers, while out and out_valid behave identically.

Structure
REQ-024 SHALL place the shared constants in package round_pkg: the 16/64/96-bit widths, the modulus 65537, and the subblock typedef.
REQ-025 SHALL implement mul as sub-module idea_mul16 (pure combinational, 16-bit in, 16-bit out), instantiated 4 times.

Verification
REQ-026 SHALL verify reset: assert rst_n=0 mid-stream -> out=0, step1..step10=0, out_valid=0 immediately.
REQ-027 SHALL verify the all-zero case: in=0, key=0, in_valid=1 -> next cycle step1=1, step4=1, step5=1, step6=1, step8=1, other steps=0, out=64'h0001_0000_0000_0001, out_valid=1.
REQ-028 SHALL verify the all-ones case: every Xi=1, every Ki=1 -> step1..step10 = 1,2,2,1,3,3,3,6,6,9 and out=64'h0007_0004_000B_0008.
REQ-029 SHALL verify mul boundaries: X1=0x0002 with K1=0x8000 -> step1=0x0000; X1=0 with K1=0 -> step1=0x0001; X1=0 with K1=0x0002 -> step1=0xFFFF.
REQ-030 SHALL verify add wrap: X2=0xFFFF with K2=0x0001 -> step2=0x0000.
REQ-031 SHALL verify the handshake: back-to-back in_valid for 3 cycles -> 3 consecutive out_valid cycles with matching results; in_valid=0 -> out_valid=0 next cycle and out held.
